// File: rtl/kcpsmx_intc.sv
// kcpsmx_intc: interrupt controller sitting in front of the kcpsmx core.
// Latches peripheral requests, masks and prioritises them, and runs the
// request / acknowledge / service handshake with the core.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-low
//   irq_src       peripheral request lines (NUM_SRC)
//   port_id       core I/O address
//   write_strobe  core output strobe, out_port carries the data
//   read_strobe   core input strobe, in_port returns the data
//   in_port       combinational read data, 0 when nothing is addressed
//   interrupt     request to the core
//   interrupt_ack one-cycle acknowledge from the core
//   active_src    index of the source being serviced
//
// Register map (offset from BASE_ADDR):
//   +0 STATUS RO, +1 MASK RW, +2 CLEAR WO (w1c),
//   +3 VECTOR RO {valid,4'b0,idx}, +4 EDGE_CFG RW (1 = rising edge)
module kcpsmx_intc #(
    parameter int NUM_SRC    = 8,
    parameter int PORT_DEPTH = 8,
    parameter int PORT_WIDTH = 8,
    parameter logic [PORT_DEPTH-1:0] BASE_ADDR = PORT_DEPTH'(8'hE0)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SRC-1:0]    irq_src,
    input  logic [PORT_DEPTH-1:0] port_id,
    input  logic                  write_strobe,
    input  logic [PORT_WIDTH-1:0] out_port,
    input  logic                  read_strobe,
    output logic [PORT_WIDTH-1:0] in_port,
    output logic                  interrupt,
    input  logic                  interrupt_ack,
    output logic [2:0]            active_src
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic [2:0] act_d;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] edge_cfg;
    logic [NUM_SRC-1:0] src_q;

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] set_v;
    logic [NUM_SRC-1:0] clr_v;
    logic [NUM_SRC-1:0] wdata;
    logic [7:0]         pend8;
    logic [7:0]         mask8;

    logic [PORT_DEPTH-1:0] offs;
    logic sel_status;
    logic sel_mask;
    logic sel_clear;
    logic sel_vector;
    logic sel_edge;

    logic       vec_valid;
    logic [2:0] vec_idx;
    logic [7:0] vec_word;

    // Address decode relative to the block base
    assign offs       = port_id - BASE_ADDR;
    assign sel_status = (offs == PORT_DEPTH'(0));
    assign sel_mask   = (offs == PORT_DEPTH'(1));
    assign sel_clear  = (offs == PORT_DEPTH'(2));
    assign sel_vector = (offs == PORT_DEPTH'(3));
    assign sel_edge   = (offs == PORT_DEPTH'(4));

    assign wdata = out_port[NUM_SRC-1:0];
    assign req   = pending & mask;
    assign pend8 = 8'(pending);
    assign mask8 = 8'(mask);

    // Edge-mode sources only fire on a 0->1 transition of the sampled line
    assign set_v = irq_src & (~edge_cfg | ~src_q);
    assign clr_v = (write_strobe && sel_clear) ? wdata : '0;

    // Lowest index wins: scan downwards so the last hit is the lowest
    always_comb begin
        vec_idx   = 3'd0;
        vec_valid = |req;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                vec_idx = 3'(i);
            end
        end
    end

    assign vec_word = {vec_valid, 4'b0000, vec_idx};

    always_comb begin
        in_port = '0;
        if (read_strobe) begin
            unique case (1'b1)
                sel_status: in_port = PORT_WIDTH'(pending);
                sel_mask:   in_port = PORT_WIDTH'(mask);
                sel_vector: in_port = PORT_WIDTH'(vec_word);
                sel_edge:   in_port = PORT_WIDTH'(edge_cfg);
                default:    in_port = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending  <= '0;
            mask     <= '0;
            edge_cfg <= '1;
            src_q    <= '0;
        end else begin
            src_q   <= irq_src;
            // Set after clear so a same-cycle request survives
            pending <= (pending & ~clr_v) | set_v;
            if (write_strobe && sel_mask) begin
                mask <= wdata;
            end
            if (write_strobe && sel_edge) begin
                edge_cfg <= wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            active_src <= 3'd0;
        end else begin
            state_q    <= state_d;
            active_src <= act_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        act_d     = active_src;
        interrupt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                interrupt = 1'b1;
                if (interrupt_ack) begin
                    state_d = SERVICE;
                    act_d   = vec_idx;
                end else if (!(|req)) begin
                    // Request withdrawn before the core took it
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (!pend8[active_src] || !mask8[active_src]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_kcpsmx_intc.sv
// tb_kcpsmx_intc: directed table-driven bench for kcpsmx_intc.
// Each table row is one clock cycle of inputs plus expected outputs.
module tb_kcpsmx_intc;

    localparam logic [7:0] ST = 8'hE0;
    localparam logic [7:0] MK = 8'hE1;
    localparam logic [7:0] CL = 8'hE2;
    localparam logic [7:0] VC = 8'hE3;
    localparam logic [7:0] EC = 8'hE4;

    logic       clk;
    logic       reset;
    logic [7:0] irq_src;
    logic [7:0] port_id;
    logic       write_strobe;
    logic [7:0] out_port;
    logic       read_strobe;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;
    logic [2:0] active_src;

    int total;
    int bad;

    typedef struct {
        logic       rst;
        logic [7:0] irq;
        logic [7:0] pid;
        logic       wr;
        logic       rd;
        logic [7:0] dout;
        logic       ack;
        logic [7:0] e_in;
        logic       e_int;
        logic       chk_as;
        logic [2:0] e_as;
    } vec_t;

    vec_t tv[$];

    kcpsmx_intc dut (
        .clk           (clk),
        .reset         (reset),
        .irq_src       (irq_src),
        .port_id       (port_id),
        .write_strobe  (write_strobe),
        .out_port      (out_port),
        .read_strobe   (read_strobe),
        .in_port       (in_port),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .active_src    (active_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", nm, act, exp);
        end
    endtask

    function automatic vec_t V(logic rst, logic [7:0] irq, logic [7:0] pid,
                               logic wr, logic rd, logic [7:0] dout,
                               logic ack, logic [7:0] ein, logic eint,
                               logic cas, logic [2:0] eas);
        vec_t v;
        v.rst = rst; v.irq = irq; v.pid = pid; v.wr = wr; v.rd = rd;
        v.dout = dout; v.ack = ack; v.e_in = ein; v.e_int = eint;
        v.chk_as = cas; v.e_as = eas;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic [7:0] irq,
                         input logic [7:0] pid, input logic wr,
                         input logic rd, input logic [7:0] dout,
                         input logic ack);
        reset = rst; irq_src = irq; port_id = pid;
        write_strobe = wr; read_strobe = rd;
        out_port = dout; interrupt_ack = ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        drive(1'b0, 8'h00, ST, 1'b0, 1'b0, 8'h00, 1'b0);

        // 1: reset values
        tv.push_back(V(1, 8'h00, ST, 0, 1, 8'h00, 0, 8'h00, 0, 1, 3'd0));
        tv.push_back(V(1, 8'h00, MK, 0, 1, 8'h00, 0, 8'h00, 0, 1, 3'd0));
        tv.push_back(V(1, 8'h00, EC, 0, 1, 8'h00, 0, 8'hFF, 0, 1, 3'd0));
        tv.push_back(V(1, 8'h00, VC, 0, 1, 8'h00, 0, 8'h00, 0, 1, 3'd0));
        tv.push_back(V(1, 8'h00, 8'hE5, 0, 1, 8'h00, 0, 8'h00, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h00, EC, 0, 0, 8'h00, 0, 8'h00, 0, 0, 3'd0));
        // 2: single source, ack, clear
        tv.push_back(V(1, 8'h00, MK, 1, 0, 8'h04, 0, 8'h00, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h04, MK, 0, 1, 8'h00, 0, 8'h04, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h00, ST, 0, 1, 8'h00, 0, 8'h04, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h00, VC, 0, 1, 8'h00, 0, 8'h82, 1, 0, 3'd0));
        tv.push_back(V(1, 8'h00, ST, 0, 1, 8'h00, 1, 8'h04, 1, 0, 3'd0));
        tv.push_back(V(1, 8'h00, ST, 0, 1, 8'h00, 0, 8'h04, 0, 1, 3'd2));
        tv.push_back(V(1, 8'h00, CL, 1, 0, 8'h04, 0, 8'h00, 0, 1, 3'd2));
        tv.push_back(V(1, 8'h00, ST, 0, 1, 8'h00, 0, 8'h00, 0, 1, 3'd2));
        tv.push_back(V(1, 8'h00, ST, 0, 1, 8'h00, 0, 8'h00, 0, 0, 3'd0));
        // 3: two sources, priority and re-request
        tv.push_back(V(1, 8'h00, MK, 1, 0, 8'hFF, 0, 8'h00, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h22, MK, 0, 1, 8'h00, 0, 8'hFF, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h22, ST, 0, 1, 8'h00, 0, 8'h22, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h00, VC, 0, 1, 8'h00, 0, 8'h81, 1, 0, 3'd0));
        tv.push_back(V(1, 8'h00, VC, 0, 1, 8'h00, 1, 8'h81, 1, 0, 3'd0));
        tv.push_back(V(1, 8'h00, CL, 1, 0, 8'h02, 0, 8'h00, 0, 1, 3'd1));
        tv.push_back(V(1, 8'h00, VC, 0, 1, 8'h00, 0, 8'h85, 0, 1, 3'd1));
        tv.push_back(V(1, 8'h00, VC, 0, 1, 8'h00, 0, 8'h85, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h00, VC, 0, 1, 8'h00, 0, 8'h85, 1, 0, 3'd0));
        tv.push_back(V(1, 8'h00, ST, 0, 0, 8'h00, 1, 8'h00, 1, 0, 3'd0));
        tv.push_back(V(1, 8'h00, CL, 1, 0, 8'h20, 0, 8'h00, 0, 1, 3'd5));
        tv.push_back(V(1, 8'h00, ST, 0, 1, 8'h00, 0, 8'h00, 0, 1, 3'd5));
        tv.push_back(V(1, 8'h00, MK, 1, 0, 8'h00, 0, 8'h00, 0, 0, 3'd0));
        // 4: level mode, set beats clear
        tv.push_back(V(1, 8'h00, EC, 1, 0, 8'h00, 0, 8'h00, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h08, EC, 0, 1, 8'h00, 0, 8'h00, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h08, CL, 1, 0, 8'h08, 0, 8'h00, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h08, ST, 0, 1, 8'h00, 0, 8'h08, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h00, CL, 1, 0, 8'h08, 0, 8'h00, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h00, ST, 0, 1, 8'h00, 0, 8'h00, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h00, EC, 1, 0, 8'hFF, 0, 8'h00, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h00, EC, 0, 1, 8'h00, 0, 8'hFF, 0, 0, 3'd0));
        // 5: masked pending, unmask, mask again before ack
        tv.push_back(V(1, 8'h01, ST, 0, 0, 8'h00, 0, 8'h00, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h00, ST, 0, 1, 8'h00, 0, 8'h01, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h00, VC, 0, 1, 8'h00, 0, 8'h00, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h00, MK, 1, 0, 8'h01, 0, 8'h00, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h00, VC, 0, 1, 8'h00, 0, 8'h80, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h00, ST, 0, 1, 8'h00, 0, 8'h01, 1, 0, 3'd0));
        tv.push_back(V(1, 8'h00, MK, 1, 0, 8'h00, 0, 8'h00, 1, 0, 3'd0));
        tv.push_back(V(1, 8'h00, ST, 0, 1, 8'h00, 0, 8'h01, 1, 0, 3'd0));
        tv.push_back(V(1, 8'h00, ST, 0, 1, 8'h00, 0, 8'h01, 0, 0, 3'd0));
        // 6: reset from ASSERT, ack in IDLE ignored
        tv.push_back(V(1, 8'h00, MK, 1, 0, 8'h01, 0, 8'h00, 0, 0, 3'd0));
        tv.push_back(V(1, 8'h00, ST, 0, 1, 8'h00, 0, 8'h01, 0, 0, 3'd0));
        tv.push_back(V(0, 8'h00, ST, 0, 0, 8'h00, 0, 8'h00, 1, 0, 3'd0));
        tv.push_back(V(1, 8'h00, ST, 0, 1, 8'h00, 0, 8'h00, 0, 1, 3'd0));
        tv.push_back(V(1, 8'h00, MK, 0, 1, 8'h00, 1, 8'h00, 0, 1, 3'd0));
        tv.push_back(V(1, 8'h00, ST, 0, 1, 8'h00, 0, 8'h00, 0, 1, 3'd0));

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].irq, tv[i].pid, tv[i].wr,
                  tv[i].rd, tv[i].dout, tv[i].ack);
            @(negedge clk);
            chk($sformatf("row%0d in_port", i), in_port, tv[i].e_in);
            chk($sformatf("row%0d interrupt", i),
                8'(interrupt), 8'(tv[i].e_int));
            if (tv[i].chk_as) begin
                chk($sformatf("row%0d active_src", i),
                    8'(active_src), 8'(tv[i].e_as));
            end
            tick();
        end

        // Latency: source 7, edge mode, counted in edges after edge k
        drive(1'b1, 8'h00, MK, 1'b1, 1'b0, 8'h80, 1'b0);
        tick();
        drive(1'b1, 8'h80, ST, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b1, 8'h00, ST, 1'b0, 1'b1, 8'h00, 1'b0);
        @(negedge clk);
        chk("lat pending", in_port, 8'h80);
        chk("lat int_k", 8'(interrupt), 8'h00);
        n = 0;
        while (!interrupt && n < 10) begin
            tick();
            n++;
            @(negedge clk);
        end
        chk("lat edges", 8'(n), 8'd1);
        chk("lat int", 8'(interrupt), 8'h01);
        tick();
        drive(1'b1, 8'h00, VC, 1'b0, 1'b1, 8'h00, 1'b1);
        @(negedge clk);
        chk("lat vector", in_port, 8'h87);
        tick();
        drive(1'b1, 8'h00, ST, 1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("svc int", 8'(interrupt), 8'h00);
        chk("svc src", 8'(active_src), 8'd7);
        tick();
        drive(1'b1, 8'h00, ST, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("svc ack ignored", 8'(interrupt), 8'h00);
        chk("svc src held", 8'(active_src), 8'd7);
        tick();
        drive(1'b1, 8'h00, CL, 1'b1, 1'b0, 8'h80, 1'b0);
        tick();
        drive(1'b1, 8'h00, ST, 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        tick();
        @(negedge clk);
        chk("end status", in_port, 8'h00);
        chk("end int", 8'(interrupt), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
